rf_wb_arbiter: RTL

- Shares the single register-file write port (we/waddr/wdata) between two write-back requesters: req0 = ALU result path, req1 = load/memory result path.
- Round-robin arbitration with valid/ready handshakes.
- One-entry registered output stage that can be frozen by a stall input.
- Per-read-port pending-write hazard flags, used by decode to stall reads of registers with writes in flight.
- Sits between the execute/memory stages and the register file.

---
 rtl/rf_wb_arbiter_pkg.sv | 14 +
 rtl/rr_arb2.sv | 36 +++
 rtl/rf_wb_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter: default widths,
// the hardwired-zero register index and the requester IDs.
package rf_wb_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 8;

  localparam int REG_ZERO = 0;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. On a conflict the requester that did not
// win the most recent grant is chosen; last_grant only moves when a grant is taken.
module rr_arb2
  import rf_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic grant_valid,
  output logic grant_id
);

  logic last_grant;

  always_comb begin
    grant_valid = valid0 | valid1;
    grant_id    = REQ_ALU;
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end else if (valid1) begin
      grant_id = REQ_MEM;
    end
  end

  // Reset to REQ_MEM so the ALU path wins the first conflict.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= REQ_MEM;
    end else if (advance && grant_valid) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the ALU and load write-back paths
// through a stallable one-entry output stage, with decode hazard flags.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              wb_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              hazard1,
  output logic              hazard2,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              load_en;
  logic              grant_valid;
  logic              grant_id;
  logic              accept;

  assign load_en = ~out_valid | ~wb_stall;

  rr_arb2 u_arb (
    .clk         (clk),
    .resetn      (resetn),
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .advance     (load_en),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Nothing is accepted while reset is asserted; requesters re-present afterwards.
  assign accept     = resetn & load_en & grant_valid;
  assign req0_ready = accept & (grant_id == REQ_ALU);
  assign req1_ready = accept & (grant_id == REQ_MEM);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_data     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (load_en) begin
        out_valid <= grant_valid;
        if (grant_valid) begin
          out_addr <= (grant_id == REQ_MEM) ? req1_addr : req0_addr;
          out_data <= (grant_id == REQ_MEM) ? req1_data : req0_data;
        end
      end
      if (req0_valid && req1_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

  // Gated by resetn so an entry caught by reset is discarded rather than written.
  assign rf_we    = resetn & out_valid & ~wb_stall & (out_addr != ZERO_ADDR);
  assign rf_waddr = out_addr;
  assign rf_wdata = out_data;

  assign hazard1 = (raddr1 != ZERO_ADDR) &
                   ((out_valid & (out_addr == raddr1)) |
                    (req0_valid & (req0_addr == raddr1)) |
                    (req1_valid & (req1_addr == raddr1)));

  assign hazard2 = (raddr2 != ZERO_ADDR) &
                   ((out_valid & (out_addr == raddr2)) |
                    (req0_valid & (req0_addr == raddr2)) |
                    (req1_valid & (req1_addr == raddr2)));

endmodule
